// File: rtl/matrix_pkg.sv
// Shared definitions for the matrix loader and the determinant engine:
// dimensions, one-hot state codes and the row-major element index.
package matrix_pkg;

  localparam int unsigned N    = 8;
  localparam int unsigned W    = 32;
  localparam int unsigned CNTW = 7;

  localparam logic [3:0] ST_FILL  = 4'b0001;
  localparam logic [3:0] ST_START = 4'b0010;
  localparam logic [3:0] ST_WAIT  = 4'b0100;
  localparam logic [3:0] ST_ACK   = 4'b1000;

  typedef enum logic [3:0] {
    S_FILL  = ST_FILL,
    S_START = ST_START,
    S_WAIT  = ST_WAIT,
    S_ACK   = ST_ACK
  } state_t;

  // Row-major flat index of element (r,c) in an n x n matrix.
  function automatic int unsigned elem_idx(input int unsigned r,
                                           input int unsigned c,
                                           input int unsigned n);
    return r * n + c;
  endfunction

endpackage

// File: rtl/matrix_loader_if.sv
// Valid/ready element stream feeding the matrix loader.
interface matrix_loader_if #(
  parameter int unsigned W = 32
);
  logic [W-1:0] In_Data;
  logic         In_Valid;
  logic         In_Ready;

  modport master (output In_Data, output In_Valid, input  In_Ready);
  modport slave  (input  In_Data, input  In_Valid, output In_Ready);
endinterface

// File: rtl/matrix_loader_rc_counter.sv
// Row/column position counter for a row-major N x N walk, with
// synchronous clear and a terminal-count flag at (N-1, N-1).
module rc_counter #(
  parameter int unsigned N   = 8,
  parameter int unsigned RCW = (N > 1) ? $clog2(N) : 1
) (
  input  logic           Clk,
  input  logic           Reset,
  input  logic           i_clr,
  input  logic           i_inc,
  output logic [RCW-1:0] o_row,
  output logic [RCW-1:0] o_col,
  output logic           o_tc
);

  logic [RCW-1:0] r_row;
  logic [RCW-1:0] r_col;
  logic           w_col_last;
  logic           w_row_last;

  assign w_col_last = (r_col == RCW'(N - 1));
  assign w_row_last = (r_row == RCW'(N - 1));

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_row <= '0;
      r_col <= '0;
    end else if (i_clr) begin
      r_row <= '0;
      r_col <= '0;
    end else if (i_inc) begin
      if (w_col_last) begin
        r_col <= '0;
        r_row <= w_row_last ? '0 : r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

  assign o_row = r_row;
  assign o_col = r_col;
  assign o_tc  = w_col_last & w_row_last;

endmodule

// File: rtl/matrix_loader.sv
// Assembles a row-major element stream into an N x N register array,
// pulses Start to the determinant engine and acknowledges its DONE state.
module matrix_loader
  import matrix_pkg::*;
#(
  parameter int unsigned N = 8,
  parameter int unsigned W = 32
) (
  input  logic                Clk,
  input  logic                Reset,
  matrix_loader_if.slave      Stream,
  input  logic                Clear,
  input  logic                Det_Done,
  output logic [N*N*W-1:0]    Mat_Flat,
  output logic                Start,
  output logic                Ack,
  output logic [6:0]          Elem_Count,
  output logic                q_Fill,
  output logic                q_Start,
  output logic                q_Wait,
  output logic                q_Ack
);

  localparam int unsigned RCW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned IW  = (N * N > 1) ? $clog2(N * N) : 1;

  state_t         r_state;
  logic [6:0]     r_count;
  logic [W-1:0]   r_mat [N*N];

  logic [RCW-1:0] w_row;
  logic [RCW-1:0] w_col;
  logic           w_tc;
  logic           w_clr;
  logic           w_xfer;
  logic [IW-1:0]  w_idx;

  // Clear outranks a simultaneous transfer; both only matter in FILL.
  assign w_clr  = (r_state == S_FILL) & Clear;
  assign w_xfer = (r_state == S_FILL) & Stream.In_Valid & ~Clear;
  assign w_idx  = IW'(elem_idx(32'(w_row), 32'(w_col), N));

  rc_counter #(
    .N   (N),
    .RCW (RCW)
  ) u_rc (
    .Clk   (Clk),
    .Reset (Reset),
    .i_clr (w_clr),
    .i_inc (w_xfer),
    .o_row (w_row),
    .o_col (w_col),
    .o_tc  (w_tc)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state <= S_FILL;
      r_count <= '0;
    end else begin
      case (r_state)
        S_FILL: begin
          if (w_clr) begin
            r_count <= '0;
          end else if (w_xfer) begin
            r_count <= r_count + 7'd1;
            if (w_tc) r_state <= S_START;
          end
        end
        S_START: r_state <= S_WAIT;
        S_WAIT:  if (Det_Done) r_state <= S_ACK;
        S_ACK: begin
          r_state <= S_FILL;
          r_count <= '0;
        end
        default: begin
          r_state <= S_FILL;
          r_count <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int unsigned i = 0; i < N * N; i++) r_mat[i] <= '0;
    end else if (w_xfer) begin
      r_mat[w_idx] <= Stream.In_Data;
    end
  end

  always_comb begin
    Mat_Flat = '0;
    for (int unsigned i = 0; i < N * N; i++) Mat_Flat[i*W +: W] = r_mat[i];
  end

  assign q_Fill          = (r_state == S_FILL);
  assign q_Start         = (r_state == S_START);
  assign q_Wait          = (r_state == S_WAIT);
  assign q_Ack           = (r_state == S_ACK);
  assign Stream.In_Ready = q_Fill;
  assign Start           = q_Start;
  assign Ack             = q_Ack;
  assign Elem_Count      = r_count;

endmodule

// File: tb/tb_matrix_loader.sv
// Self-checking bench for matrix_loader: scenario tasks compare the DUT
// against an element-array model of the loaded matrix.
module tb_matrix_loader;

  localparam int NE = 64;

  logic          Clk = 1'b0;
  logic          Reset;
  logic          Clear;
  logic          Det_Done;
  logic [2047:0] Mat_Flat;
  logic          Start;
  logic          Ack;
  logic [6:0]    Elem_Count;
  logic          q_Fill, q_Start, q_Wait, q_Ack;

  matrix_loader_if #(.W(32)) bus ();

  matrix_loader #(.N(8), .W(32)) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .Stream     (bus.slave),
    .Clear      (Clear),
    .Det_Done   (Det_Done),
    .Mat_Flat   (Mat_Flat),
    .Start      (Start),
    .Ack        (Ack),
    .Elem_Count (Elem_Count),
    .q_Fill     (q_Fill),
    .q_Start    (q_Start),
    .q_Wait     (q_Wait),
    .q_Ack      (q_Ack)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int passes = 0;
  logic [31:0] exp_mat [NE];
  logic [31:0] src [NE];

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  function automatic int first_diff();
    for (int i = 0; i < NE; i++)
      if (Mat_Flat[i*32 +: 32] !== exp_mat[i]) return i;
    return -1;
  endfunction

  // Streams all of src; mode 0 = always valid, 1 = valid pattern 1,0,0, 2 = random gaps.
  task automatic load_matrix(input int mode);
    int n = 0;
    int cyc = 0;
    logic v;
    while (n < NE && cyc < 1000) begin
      case (mode)
        0:       v = 1'b1;
        1:       v = (cyc % 3 == 0);
        default: v = 1'($urandom_range(0, 1));
      endcase
      bus.In_Valid = v;
      bus.In_Data  = v ? src[n] : $urandom;
      checks++;
      if (bus.In_Ready !== 1'b1) $display("FAIL ready_in_fill: got %b want 1 (word %0d)", bus.In_Ready, n);
      else passes++;
      tick();
      if (v) begin
        exp_mat[n] = src[n];
        n++;
      end
      checks++;
      if (Elem_Count !== 7'(n)) $display("FAIL elem_count: got %0d want %0d", Elem_Count, n);
      else passes++;
      checks++;
      if (Start !== (n == NE)) $display("FAIL start_timing: got %b want %b after %0d words", Start, (n == NE), n);
      else passes++;
      cyc++;
    end
    bus.In_Valid = 1'b0;
    if (n < NE) begin
      checks++;
      $display("FAIL load_budget: got %0d words want %0d", n, NE);
    end
  endtask

  // Called in START right after the last transfer; ends one cycle later in WAIT.
  task automatic check_loaded(input logic done_early);
    int d;
    d = first_diff();
    checks++;
    if (d != -1) $display("FAIL matrix_loaded: elem %0d got %h want %h", d, Mat_Flat[d*32 +: 32], exp_mat[d]);
    else passes++;
    checks++;
    if ({q_Fill, q_Start, q_Wait, q_Ack, bus.In_Ready, Elem_Count} !== {4'b0100, 1'b0, 7'd64})
      $display("FAIL start_state: got q=%b%b%b%b rdy=%b cnt=%0d want q=0100 rdy=0 cnt=64",
               q_Fill, q_Start, q_Wait, q_Ack, bus.In_Ready, Elem_Count);
    else passes++;
    Det_Done = done_early;
    tick();
    checks++;
    if ({q_Wait, Start, bus.In_Ready} !== 3'b100)
      $display("FAIL enter_wait: got wait=%b start=%b rdy=%b want 1 0 0", q_Wait, Start, bus.In_Ready);
    else passes++;
  endtask

  // Holds Det_Done low for `hold` cycles in WAIT (offering data meanwhile), then completes ACK.
  task automatic finish_handshake(input int hold);
    int d;
    for (int i = 0; i < hold; i++) begin
      Det_Done     = 1'b0;
      bus.In_Valid = 1'b1;
      bus.In_Data  = $urandom;
      tick();
      d = first_diff();
      checks++;
      if (q_Wait !== 1'b1 || bus.In_Ready !== 1'b0 || Elem_Count !== 7'd64 || Ack !== 1'b0 || d != -1)
        $display("FAIL wait_hold: cyc %0d wait=%b rdy=%b cnt=%0d ack=%b diff=%0d want 1 0 64 0 -1",
                 i, q_Wait, bus.In_Ready, Elem_Count, Ack, d);
      else passes++;
    end
    bus.In_Valid = 1'b0;
    Det_Done     = 1'b1;
    tick();
    checks++;
    if ({q_Ack, Ack, q_Wait} !== 3'b110) $display("FAIL ack_pulse: got qack=%b ack=%b wait=%b want 1 1 0", q_Ack, Ack, q_Wait);
    else passes++;
    Det_Done = 1'b0;
    tick();
    checks++;
    if ({q_Fill, Ack, bus.In_Ready, Elem_Count} !== {3'b101, 7'd0})
      $display("FAIL back_to_fill: got fill=%b ack=%b rdy=%b cnt=%0d want 1 0 1 0", q_Fill, Ack, bus.In_Ready, Elem_Count);
    else passes++;
  endtask

  task automatic partial_load(input int count);
    for (int k = 0; k < count; k++) begin
      bus.In_Valid = 1'b1;
      bus.In_Data  = $urandom;
      exp_mat[k]   = bus.In_Data;
      tick();
    end
    bus.In_Valid = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    #12;
    checks++;
    if (Mat_Flat !== '0 || {q_Fill, q_Start, q_Wait, q_Ack} !== 4'b1000 || Elem_Count !== 7'd0 || Start !== 1'b0 || Ack !== 1'b0)
      $display("FAIL reset_state: q=%b%b%b%b cnt=%0d start=%b ack=%b want q=1000 cnt=0 0 0",
               q_Fill, q_Start, q_Wait, q_Ack, Elem_Count, Start, Ack);
    else passes++;
    @(negedge Clk);
    Reset = 1'b0;
    tick();
    checks++;
    if ({q_Fill, bus.In_Ready, Elem_Count} !== {2'b11, 7'd0})
      $display("FAIL post_reset: fill=%b rdy=%b cnt=%0d want 1 1 0", q_Fill, bus.In_Ready, Elem_Count);
    else passes++;
    for (int i = 0; i < NE; i++) exp_mat[i] = '0;
  endtask

  task automatic test_full_load();
    for (int k = 0; k < NE; k++) src[k] = 32'(k + 1);
    load_matrix(0);
    checks++;
    if (Mat_Flat[(7*8+7)*32 +: 32] !== 32'd64 || Mat_Flat[(2*8+5)*32 +: 32] !== 32'd22)
      $display("FAIL full_load_values: e77=%0d e25=%0d want 64 22", Mat_Flat[(7*8+7)*32 +: 32], Mat_Flat[(2*8+5)*32 +: 32]);
    else passes++;
    check_loaded(1'b0);
    finish_handshake(20);
  endtask

  task automatic test_gapped();
    for (int k = 0; k < NE; k++) src[k] = 32'(k + 1);
    load_matrix(1);
    check_loaded(1'b0);
    finish_handshake(2);
  endtask

  task automatic test_done_early();
    for (int k = 0; k < NE; k++) src[k] = $urandom;
    load_matrix(0);
    check_loaded(1'b1);
    finish_handshake(0);
  endtask

  task automatic test_clear();
    int d;
    partial_load(10);
    Clear        = 1'b1;
    bus.In_Valid = 1'b1;
    bus.In_Data  = ~exp_mat[10];
    tick();
    Clear        = 1'b0;
    bus.In_Valid = 1'b0;
    d = first_diff();
    checks++;
    if (Elem_Count !== 7'd0 || d != -1) $display("FAIL clear_no_write: cnt=%0d diff=%0d want 0 -1", Elem_Count, d);
    else passes++;
    for (int k = 0; k < NE; k++) src[k] = 32'hFFFF_FFFF;
    load_matrix(0);
    checks++;
    if (Mat_Flat !== '1) $display("FAIL clear_all_minus1: elem0=%h elem63=%h want ffffffff", Mat_Flat[31:0], Mat_Flat[2047:2016]);
    else passes++;
    check_loaded(1'b0);
    finish_handshake(1);
  endtask

  task automatic test_reset_midfill();
    partial_load(30);
    #3;
    Reset = 1'b1;
    #1;
    checks++;
    if (Mat_Flat !== '0 || {q_Fill, q_Start, q_Wait, q_Ack} !== 4'b1000 || Elem_Count !== 7'd0 || Start !== 1'b0 || Ack !== 1'b0)
      $display("FAIL async_reset: q=%b%b%b%b cnt=%0d start=%b want q=1000 cnt=0 0", q_Fill, q_Start, q_Wait, q_Ack, Elem_Count, Start);
    else passes++;
    #1;
    Reset = 1'b0;
    for (int i = 0; i < NE; i++) exp_mat[i] = '0;
    tick();
    test_full_load();
  endtask

  task automatic test_ignored_clear();
    for (int k = 0; k < NE; k++) src[k] = $urandom;
    load_matrix(0);
    check_loaded(1'b0);
    Clear = 1'b1;
    finish_handshake(3);
    Clear = 1'b0;
  endtask

  task automatic test_random();
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < NE; k++) src[k] = $urandom;
      load_matrix(2);
      check_loaded(1'b0);
      finish_handshake($urandom_range(1, 5));
    end
  endtask

  initial begin
    Reset        = 1'b1;
    Clear        = 1'b0;
    Det_Done     = 1'b0;
    bus.In_Valid = 1'b0;
    bus.In_Data  = '0;
    test_reset();
    test_full_load();
    test_gapped();
    test_done_early();
    test_clear();
    test_reset_midfill();
    test_ignored_clear();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", passes, checks);
    $fatal(1);
  end

endmodule

// File: doc/matrix_loader.md
Name: matrix_loader

Overview:
Upstream feeder for the 8x8 determinant engine. Accepts a row-major stream of signed 32-bit matrix elements over a valid/ready handshake and assembles them into a full N x N register array. It then pulses Start to the engine, holds the matrix stable while the engine computes, and acknowledges the engine's DONE state before accepting the next matrix.

Parameters:
N, 8, matrix dimension (rows = cols)
W, 32, element width in bits, two's-complement signed

Ports:
Clk  in  1  clock
Reset  in  1  asynchronous, active-high reset
In_Data  in  W  element value, row-major order
In_Valid  in  1  In_Data valid this cycle
In_Ready  out  1  loader accepts In_Data this cycle
Clear  in  1  discard partially loaded matrix
Det_Done  in  1  engine in DONE state (engine q_Done)
Mat_Flat  out  N*N*W  element (r,c) at bits [(r*N+c)*W +: W]
Start  out  1  one-cycle start pulse to engine
Ack  out  1  one-cycle acknowledge to engine
Elem_Count  out  7  elements accepted in current matrix, 0..N*N
q_Fill, q_Start, q_Wait, q_Ack  out  1 each  one-hot state bits

Behaviour:
- Reset, asynchronous, active-high; clock Clk. On Reset: state FILL, row/col counters 0, Elem_Count 0, all Mat_Flat elements 0, Start 0, Ack 0. A Reset mid-fill or mid-wait aborts everything; the engine's own Reset is separate.
- States are one-hot FILL, START, WAIT, ACK, and are exposed on the q_ outputs.
- FILL: In_Ready=1. A transfer occurs when In_Valid & In_Ready at the Clk edge. The transfer writes In_Data to element (row,col). Col increments; at col=N-1 it wraps to 0 and row increments. Elem_Count increments.
- Acceptance of element N*N-1 (row=N-1, col=N-1): next state START, counters return to 0, and Elem_Count shows N*N.
- START: Start=1 for exactly one cycle, In_Ready=0. Next state is WAIT.
- WAIT: In_Ready=0. Mat_Flat is held constant. Stays until Det_Done=1 is sampled, then goes to ACK.
- ACK: Ack=1 for exactly one cycle. Next state is FILL, and Elem_Count returns to 0 on entry.
- Mat_Flat keeps the previous matrix until each element is overwritten. There is no zeroing between matrices.
- Clear in FILL: counters and Elem_Count return to 0 next cycle, and no write occurs that cycle even if In_Valid=1. Clear in START, WAIT or ACK is ignored.
- Clear has priority over a simultaneous transfer.
- In_Valid gaps in FILL are allowed; the counters hold.
- Det_Done already high on entry to WAIT: transition to ACK on the next edge (minimum WAIT dwell is 1 cycle).
- Start, Ack and In_Ready are registered-state decodes with no combinational path from inputs.
- Elements are stored bit-exact; no sign extension or truncation.

Decomposition:
- Shared package matrix_pkg holds N, W, localparams for the one-hot state codes, and an elem_idx function (r*N+c). The same package is used by the determinant engine.
- One natural sub-module, rc_counter: row/col counter with wrap, clear and a terminal-count flag.

Test Plan:
- Full load: stream 64 words with value k+1 (k=0..63), In_Valid held high. Required: element (r,c) = 8r+c+1; Start is high exactly one cycle after the 64th transfer; In_Ready is 0 afterward.
- Gapped stream: In_Valid toggles 1,0,0,1... across 64 words. Required: identical Mat_Flat and a single Start, with Elem_Count advancing only on transfers.
- Handshake: in WAIT, hold Det_Done=0 for 20 cycles, then 1. Required: In_Ready=0 throughout and Mat_Flat unchanged; Ack pulses once; the next cycle is q_Fill=1 with Elem_Count=0.
- Clear: load 10 words, assert Clear together with In_Valid=1, then load 64 words of value 0xFFFFFFFF. Required: all elements read -1, and Start follows only after the 64th new word.
- Reset mid-fill: after 30 words, assert Reset asynchronously between edges. Required: outputs are immediately 0 and q_Fill=1; a fresh 64-word load then behaves as in the full-load test.
- Ignored Clear: assert Clear during WAIT. Required: no state change, and Ack still occurs after Det_Done.
